// File: rtl/ce_prescaler_pkg.sv
// Shared types for the ce_prescaler clock-enable generator.
// The state encoding is fixed so that IDLE is 0 and RUN is 1.
package ce_prescaler_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic xfer(input logic valid, input logic ready);
      return valid && ready;
   endfunction

endpackage

// File: rtl/ce_div_counter.sv
// Period counter for ce_prescaler.
// It has a clear and an increment control, and it flags when the count equals the terminal value.
module ce_div_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] tc_val,
   output logic [WIDTH-1:0] cnt,
   output logic             tc
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The count wraps to zero on terminal, so equality alone is enough.
   // It never has to step past all-ones.
   assign tc  = (cnt_q == tc_val);
   assign cnt = cnt_q;

endmodule

// File: rtl/ce_prescaler.sv
// Programmable clock-enable prescaler: one ce_out pulse every (div+1) clk_in cycles.
// A new divisor can be loaded at run time, and it takes effect only at a period boundary.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | stopped, counter held at 0, cfg written directly
// ST_RUN  | counting, cfg buffered until next terminal
module ce_prescaler #(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 0,
   parameter int TCNT_W      = 8
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              en,
   input  logic              cfg_valid,
   input  logic [WIDTH-1:0]  cfg_div,
   output logic              cfg_ready,
   output logic              ce_out,
   output logic              busy,
   output logic [TCNT_W-1:0] tick_cnt
);

   import ce_prescaler_pkg::*;

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    div_reg_q, div_reg_d;
   logic [WIDTH-1:0]    pend_div_q, pend_div_d;
   logic                pend_q, pend_d;
   logic                ce_out_q, ce_out_d;
   logic [TCNT_W-1:0]   tick_cnt_q, tick_cnt_d;

   logic                cnt_clr;
   logic                cnt_inc;
   logic                cnt_tc;
   logic [WIDTH-1:0]    cnt;
   logic                accept;

   ce_div_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk_in (clk_in),
      .rst    (rst),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .tc_val (div_reg_q),
      .cnt    (cnt),
      .tc     (cnt_tc)
   );

   assign cfg_ready = !pend_q;
   assign accept    = xfer(cfg_valid, cfg_ready);

   always_comb begin
      state_d    = state_q;
      div_reg_d  = div_reg_q;
      pend_div_d = pend_div_q;
      pend_d     = pend_q;
      ce_out_d   = 1'b0;
      tick_cnt_d = tick_cnt_q;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (accept) begin
               div_reg_d = cfg_div;
            end
            if (en) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!en) begin
               // Stopping wins over a coincident terminal count.
               // Any buffered or just-offered divisor lands in div_reg.
               state_d = ST_IDLE;
               cnt_clr = 1'b1;
               if (pend_q) begin
                  div_reg_d = pend_div_q;
                  pend_d    = 1'b0;
               end else if (accept) begin
                  div_reg_d = cfg_div;
               end
            end else begin
               if (accept) begin
                  pend_div_d = cfg_div;
                  pend_d     = 1'b1;
               end
               if (cnt_tc) begin
                  cnt_clr    = 1'b1;
                  ce_out_d   = 1'b1;
                  tick_cnt_d = tick_cnt_q + 1'b1;
                  if (pend_q) begin
                     div_reg_d = pend_div_q;
                     pend_d    = 1'b0;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         div_reg_q  <= DEF_DIV;
         pend_div_q <= '0;
         pend_q     <= 1'b0;
         ce_out_q   <= 1'b0;
         tick_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         div_reg_q  <= div_reg_d;
         pend_div_q <= pend_div_d;
         pend_q     <= pend_d;
         ce_out_q   <= ce_out_d;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   assign ce_out   = ce_out_q;
   assign busy     = (state_q == ST_RUN);
   assign tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_ce_prescaler.sv
// Directed bench for ce_prescaler: a vector table followed by hand-written multi-cycle sequences.
// It also covers a small instance for the counter-wrap and tick-wrap boundaries.
module tb_ce_prescaler;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [15:0] cfg_div = '0;
   logic        cfg_ready;
   logic        ce_out;
   logic        busy;
   logic [7:0]  tick_cnt;

   logic        s_rst = 1'b1;
   logic        s_en = 1'b0;
   logic        s_cfg_valid = 1'b0;
   logic [3:0]  s_cfg_div = '0;
   logic        s_cfg_ready;
   logic        s_ce_out;
   logic        s_busy;
   logic [1:0]  s_tick_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   ce_prescaler #(.WIDTH(16), .DEFAULT_DIV(0), .TCNT_W(8)) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .ce_out    (ce_out),
      .busy      (busy),
      .tick_cnt  (tick_cnt)
   );

   ce_prescaler #(.WIDTH(4), .DEFAULT_DIV(15), .TCNT_W(2)) dut_s (
      .clk_in    (clk_in),
      .rst       (s_rst),
      .en        (s_en),
      .cfg_valid (s_cfg_valid),
      .cfg_div   (s_cfg_div),
      .cfg_ready (s_cfg_ready),
      .ce_out    (s_ce_out),
      .busy      (s_busy),
      .tick_cnt  (s_tick_cnt)
   );

   typedef struct packed {
      logic        rst;
      logic        en;
      logic        vld;
      logic [15:0] div;
      logic        ce;
      logic        rdy;
      logic        bsy;
      logic [7:0]  tick;
   } vec_t;

   localparam int NV = 19;
   vec_t vec [NV];

   function automatic vec_t mk(input logic r, input logic e, input logic v, input logic [15:0] d,
                               input logic c, input logic rd, input logic b, input logic [7:0] t);
      vec_t x;
      x.rst = r; x.en = e; x.vld = v; x.div = d;
      x.ce = c; x.rdy = rd; x.bsy = b; x.tick = t;
      return x;
   endfunction

   task automatic step(input logic r, input logic e, input logic v, input logic [15:0] d);
      @(negedge clk_in);
      rst = r; en = e; cfg_valid = v; cfg_div = d;
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string nm, input logic c, input logic rd, input logic b, input logic [7:0] t);
      checks++;
      if ({ce_out, cfg_ready, busy, tick_cnt} !== {c, rd, b, t}) begin
         errors++;
         $display("FAIL %s: got ce=%0b rdy=%0b busy=%0b tick=%0d, want ce=%0b rdy=%0b busy=%0b tick=%0d",
                  nm, ce_out, cfg_ready, busy, tick_cnt, c, rd, b, t);
      end
   endtask

   task automatic s_step(input logic r, input logic e);
      @(negedge clk_in);
      s_rst = r; s_en = e; s_cfg_valid = 1'b0; s_cfg_div = '0;
      @(posedge clk_in);
      #1;
   endtask

   task automatic s_chk(input string nm, input logic c, input logic b, input logic [1:0] t);
      checks++;
      if ({s_ce_out, s_busy, s_tick_cnt} !== {c, b, t}) begin
         errors++;
         $display("FAIL %s: got ce=%0b busy=%0b tick=%0d, want ce=%0b busy=%0b tick=%0d",
                  nm, s_ce_out, s_busy, s_tick_cnt, c, b, t);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset for 3 cycles, then run div=0, then stop.
      // After that, reset again, load div=3 in IDLE, and run.
      vec[0]  = mk(1, 0, 0, 16'd0, 0, 1, 0, 8'd0);
      vec[1]  = mk(1, 0, 0, 16'd0, 0, 1, 0, 8'd0);
      vec[2]  = mk(1, 0, 0, 16'd0, 0, 1, 0, 8'd0);
      vec[3]  = mk(0, 1, 0, 16'd0, 0, 1, 1, 8'd0);
      vec[4]  = mk(0, 1, 0, 16'd0, 1, 1, 1, 8'd1);
      vec[5]  = mk(0, 1, 0, 16'd0, 1, 1, 1, 8'd2);
      vec[6]  = mk(0, 1, 0, 16'd0, 1, 1, 1, 8'd3);
      vec[7]  = mk(0, 0, 0, 16'd0, 0, 1, 0, 8'd3);
      vec[8]  = mk(1, 0, 0, 16'd0, 0, 1, 0, 8'd0);
      vec[9]  = mk(0, 0, 1, 16'd3, 0, 1, 0, 8'd0);
      vec[10] = mk(0, 1, 0, 16'd0, 0, 1, 1, 8'd0);
      vec[11] = mk(0, 1, 0, 16'd0, 0, 1, 1, 8'd0);
      vec[12] = mk(0, 1, 0, 16'd0, 0, 1, 1, 8'd0);
      vec[13] = mk(0, 1, 0, 16'd0, 0, 1, 1, 8'd0);
      vec[14] = mk(0, 1, 0, 16'd0, 1, 1, 1, 8'd1);
      vec[15] = mk(0, 1, 0, 16'd0, 0, 1, 1, 8'd1);
      vec[16] = mk(0, 1, 0, 16'd0, 0, 1, 1, 8'd1);
      vec[17] = mk(0, 1, 0, 16'd0, 0, 1, 1, 8'd1);
      vec[18] = mk(0, 1, 0, 16'd0, 1, 1, 1, 8'd2);

      for (int i = 0; i < NV; i++) begin
         step(vec[i].rst, vec[i].en, vec[i].vld, vec[i].div);
         chk($sformatf("vec%0d", i), vec[i].ce, vec[i].rdy, vec[i].bsy, vec[i].tick);
      end

      // Continue with div=3 until there have been 10 pulses.
      for (int p = 3; p <= 10; p++) begin
         for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 16'd0);
            chk($sformatf("div3_gap_p%0d", p), 0, 1, 1, 8'(p - 1));
         end
         step(0, 1, 0, 16'd0);
         chk($sformatf("div3_pulse_p%0d", p), 1, 1, 1, 8'(p));
      end

      // Reload to 1 in the middle of the period.
      // The current period stays at 4 cycles, then the period becomes 2.
      step(0, 1, 0, 16'd0);  chk("t3_cnt1", 0, 1, 1, 8'd10);
      step(0, 1, 1, 16'd1);  chk("t3_accept", 0, 0, 1, 8'd10);
      step(0, 1, 0, 16'd0);  chk("t3_wait", 0, 0, 1, 8'd10);
      step(0, 1, 0, 16'd0);  chk("t3_term_old", 1, 1, 1, 8'd11);
      step(0, 1, 0, 16'd0);  chk("t3_p2_gap_a", 0, 1, 1, 8'd11);
      step(0, 1, 0, 16'd0);  chk("t3_p2_pulse_a", 1, 1, 1, 8'd12);
      step(0, 1, 0, 16'd0);  chk("t3_p2_gap_b", 0, 1, 1, 8'd12);
      step(0, 1, 0, 16'd0);  chk("t3_p2_pulse_b", 1, 1, 1, 8'd13);

      // Switch to div=4.
      // Then offer div=2 exactly on a terminal edge.
      step(0, 1, 1, 16'd4);  chk("t4_load4", 0, 0, 1, 8'd13);
      step(0, 1, 0, 16'd0);  chk("t4_term_to4", 1, 1, 1, 8'd14);
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 0, 16'd0);  chk("t4_d4_gap", 0, 1, 1, 8'd14);
      end
      step(0, 1, 1, 16'd2);  chk("t4_accept_on_term", 1, 0, 1, 8'd15);
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 0, 16'd0);  chk("t4_extra5_gap", 0, 0, 1, 8'd15);
      end
      step(0, 1, 0, 16'd0);  chk("t4_extra5_term", 1, 1, 1, 8'd16);
      for (int p = 17; p <= 18; p++) begin
         step(0, 1, 0, 16'd0);  chk("t4_d2_gap_a", 0, 1, 1, 8'(p - 1));
         step(0, 1, 0, 16'd0);  chk("t4_d2_gap_b", 0, 1, 1, 8'(p - 1));
         step(0, 1, 0, 16'd0);  chk("t4_d2_pulse", 1, 1, 1, 8'(p));
      end

      // Drop en on the terminal cycle while div=6 is pending.
      step(0, 1, 1, 16'd6);  chk("t5_pend", 0, 0, 1, 8'd18);
      step(0, 1, 0, 16'd0);  chk("t5_at_tc", 0, 0, 1, 8'd18);
      step(0, 0, 0, 16'd0);  chk("t5_stop_no_pulse", 0, 1, 0, 8'd18);
      step(0, 1, 0, 16'd0);  chk("t5_restart", 0, 1, 1, 8'd18);
      for (int k = 0; k < 6; k++) begin
         step(0, 1, 0, 16'd0);  chk("t5_d6_gap", 0, 1, 1, 8'd18);
      end
      step(0, 1, 0, 16'd0);  chk("t5_d6_pulse", 1, 1, 1, 8'd19);

      // Reset while running with a divisor pending.
      // The pending value must be dropped and div must return to 0.
      step(0, 1, 1, 16'd9);  chk("t6_pend", 0, 0, 1, 8'd19);
      step(1, 1, 0, 16'd0);  chk("t6_reset", 0, 1, 0, 8'd0);
      step(0, 1, 0, 16'd0);  chk("t6_restart", 0, 1, 1, 8'd0);
      step(0, 1, 0, 16'd0);  chk("t6_div0_pulse", 1, 1, 1, 8'd1);
      step(0, 0, 0, 16'd0);

      // Small instance: WIDTH=4 with div=15 gives a period of 16.
      // With TCNT_W=2, tick_cnt wraps from 3 to 0.
      s_step(1, 0);
      s_step(1, 0);  s_chk("s_reset", 0, 0, 2'd0);
      s_step(0, 1);  s_chk("s_start", 0, 1, 2'd0);
      for (int k = 1; k <= 64; k++) begin
         s_step(0, 1);
         s_chk($sformatf("s_cyc%0d", k), (k % 16) == 0, 1, 2'((k / 16) % 4));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
